order_ingress_arbiter: RTL and testbench

Parametrised N-source order merger that replaces the fixed two-way UDP/bot glue in front of order_book_top. It arbitrates between NUM_SRC first-word-fall-through order FIFOs and pops at most one word per cycle while the engine is not busy. Filtered orders go to the engine input, tagged with their source index. It supports strict priority with a starvation guard or round-robin, per-source enables, and NOP filtering/counting. It sits in the clk_engine domain, between the ingress FIFOs (UDP, bot, UART, future feeds) and order_book_top.

---
 rtl/order_ingress_arbiter_if.sv | 27 ++
 rtl/order_ingress_arbiter.sv | 159 +++++++++++++++
 tb/tb_order_ingress_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/order_ingress_arbiter_if.sv
// Order ingress bus: FWFT source FIFO heads in, pop strobes back, one merged order stream out.
// master = arbiter side, slave = FIFO/engine side.
interface order_ingress_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32
) ();
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        src_enable;
  logic [NUM_SRC-1:0]        src_empty;
  logic [NUM_SRC*DATA_W-1:0] src_dout;
  logic [NUM_SRC-1:0]        src_rd_en;
  logic                      engine_busy;
  logic                      ob_input_valid;
  logic [DATA_W-1:0]         ob_input_data;
  logic [SRC_W-1:0]          ob_input_src;

  modport master (
    input  src_enable, src_empty, src_dout, engine_busy,
    output src_rd_en, ob_input_valid, ob_input_data, ob_input_src
  );

  modport slave (
    output src_enable, src_empty, src_dout, engine_busy,
    input  src_rd_en, ob_input_valid, ob_input_data, ob_input_src
  );
endinterface

// File: rtl/order_ingress_arbiter.sv
// N-source order merger in front of the order book: strict priority with starvation guard or
// round-robin, NOP filtering. Define ARB_STATS_EN to add per-source grant and busy-stall counters.
module order_ingress_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int DATA_W       = 32,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 16,
  parameter int NOP_FILTER   = 1,
  parameter int CNT_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  order_ingress_arbiter_if.master  bus,
  output logic                     starve_force,
  output logic [CNT_W-1:0]         nop_drop_count
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_SRC*CNT_W-1:0] grant_count,
  output logic [CNT_W-1:0]         busy_stall_count
`endif
);

  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam bit GUARD_EN = (ARB_MODE == 0) && (STARVE_LIMIT > 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] starving;
  logic               pop;
  logic               guard_hit;
  logic [SRC_W-1:0]   low_idx;
  logic [SRC_W-1:0]   force_idx;
  logic [SRC_W-1:0]   rr_idx;
  logic [SRC_W-1:0]   winner;
  logic [DATA_W-1:0]  head;
  logic               head_zero;

  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]  wait_q [NUM_SRC];
  logic [WAIT_W-1:0]  wait_d [NUM_SRC];
  logic [CNT_W-1:0]   nop_q, nop_d;

  assign req = bus.src_enable & ~bus.src_empty;
  assign pop = ~rst & ~bus.engine_busy & (|req);

  // Descending scans so the lowest matching index is the last one written.
  always_comb begin
    int idx;
    low_idx   = '0;
    force_idx = '0;
    rr_idx    = '0;
    starving  = '0;
    idx       = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) low_idx = SRC_W'(i);
      if (GUARD_EN && req[i] && (wait_q[i] >= WAIT_MAX)) begin
        starving[i] = 1'b1;
        force_idx   = SRC_W'(i);
      end
    end
    guard_hit = |starving;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req[idx]) rr_idx = SRC_W'(idx);
    end
  end

  always_comb begin
    if (ARB_MODE == 1)  winner = rr_idx;
    else if (guard_hit) winner = force_idx;
    else                winner = low_idx;
  end

  assign head      = bus.src_dout[int'(winner)*DATA_W +: DATA_W];
  assign head_zero = (head == '0);

  always_comb begin
    bus.src_rd_en      = '0;
    bus.ob_input_valid = 1'b0;
    bus.ob_input_data  = '0;
    bus.ob_input_src   = '0;
    starve_force       = 1'b0;
    if (pop) begin
      bus.src_rd_en      = NUM_SRC'(1) << winner;
      bus.ob_input_valid = (NOP_FILTER == 0) || !head_zero;
      bus.ob_input_data  = head;
      bus.ob_input_src   = winner;
      starve_force       = guard_hit;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    nop_d    = nop_q;
    if (ARB_MODE == 1 && pop) begin
      if (int'(winner) == NUM_SRC - 1) rr_ptr_d = '0;
      else                             rr_ptr_d = winner + SRC_W'(1);
    end
    if (pop && head_zero && (nop_q != '1)) nop_d = nop_q + CNT_W'(1);
    // A dropped request (empty or disabled) forgets its accumulated wait even while the engine is busy.
    for (int i = 0; i < NUM_SRC; i++) begin
      wait_d[i] = wait_q[i];
      if (!GUARD_EN || !req[i]) begin
        wait_d[i] = '0;
      end else if (pop) begin
        if (winner == SRC_W'(i))        wait_d[i] = '0;
        else if (wait_q[i] < WAIT_MAX) wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      nop_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      nop_q    <= nop_d;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign nop_drop_count = nop_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] grant_q [NUM_SRC];
  logic [CNT_W-1:0] grant_d [NUM_SRC];
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((|req) && bus.engine_busy && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_d[i] = grant_q[i];
      if (bus.ob_input_valid && (winner == SRC_W'(i)) && (grant_q[i] != '1))
        grant_d[i] = grant_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) grant_q[i] <= '0;
    end else begin
      stall_q <= stall_d;
      for (int i = 0; i < NUM_SRC; i++) grant_q[i] <= grant_d[i];
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_grant_out
    assign grant_count[g*CNT_W +: CNT_W] = grant_q[g];
  end
  assign busy_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_order_ingress_arbiter.sv
// Drives three arbiter builds (strict limit 4, round-robin, strict limit 16 without NOP filter)
// from per-instance FIFO queues and compares every cycle against a queue-level reference model.
module tb_order_ingress_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  en;
  logic        busy;
  logic [2:0]  emp  [3];
  logic [95:0] dout [3];
  logic [2:0]  rd   [3];
  logic        vld  [3];
  logic [31:0] dat  [3];
  logic [1:0]  srcx [3];
  logic        sf   [3];
  logic [31:0] nop  [3];

  logic [31:0] q [3][3][$];
  int          rrp [3];
  int          wt  [3][3];
  int          nopm [3];

  int errors = 0;
  int checks = 0;

  order_ingress_arbiter_if #(.NUM_SRC(3), .DATA_W(32)) if0 ();
  order_ingress_arbiter_if #(.NUM_SRC(3), .DATA_W(32)) if1 ();
  order_ingress_arbiter_if #(.NUM_SRC(3), .DATA_W(32)) if2 ();

  order_ingress_arbiter #(.NUM_SRC(3), .DATA_W(32), .ARB_MODE(0), .STARVE_LIMIT(4),
                          .NOP_FILTER(1), .CNT_W(32)) u_sp4 (
    .clk(clk), .rst(rst), .bus(if0.master), .starve_force(sf[0]), .nop_drop_count(nop[0]));
  order_ingress_arbiter #(.NUM_SRC(3), .DATA_W(32), .ARB_MODE(1), .STARVE_LIMIT(16),
                          .NOP_FILTER(1), .CNT_W(32)) u_rr (
    .clk(clk), .rst(rst), .bus(if1.master), .starve_force(sf[1]), .nop_drop_count(nop[1]));
  order_ingress_arbiter #(.NUM_SRC(3), .DATA_W(32), .ARB_MODE(0), .STARVE_LIMIT(16),
                          .NOP_FILTER(0), .CNT_W(32)) u_sp16 (
    .clk(clk), .rst(rst), .bus(if2.master), .starve_force(sf[2]), .nop_drop_count(nop[2]));

  assign if0.src_enable = en;   assign if1.src_enable = en;   assign if2.src_enable = en;
  assign if0.engine_busy = busy; assign if1.engine_busy = busy; assign if2.engine_busy = busy;
  assign if0.src_empty = emp[0]; assign if1.src_empty = emp[1]; assign if2.src_empty = emp[2];
  assign if0.src_dout = dout[0]; assign if1.src_dout = dout[1]; assign if2.src_dout = dout[2];
  assign rd[0] = if0.src_rd_en;  assign rd[1] = if1.src_rd_en;  assign rd[2] = if2.src_rd_en;
  assign vld[0] = if0.ob_input_valid; assign vld[1] = if1.ob_input_valid; assign vld[2] = if2.ob_input_valid;
  assign dat[0] = if0.ob_input_data;  assign dat[1] = if1.ob_input_data;  assign dat[2] = if2.ob_input_data;
  assign srcx[0] = if0.ob_input_src;  assign srcx[1] = if1.ob_input_src;  assign srcx[2] = if2.ob_input_src;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mode_of(int k);
    return (k == 1) ? 1 : 0;
  endfunction
  function automatic int limit_of(int k);
    return (k == 0) ? 4 : 16;
  endfunction
  function automatic int nf_of(int k);
    return (k == 2) ? 0 : 1;
  endfunction

  task automatic chk(string tag, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", tag, k, $time, got, exp);
    end
  endtask

  task automatic fill(int i, int n, int zpct);
    logic [31:0] v;
    for (int j = 0; j < n; j++) begin
      v = ($urandom_range(99) < zpct) ? 32'h0 : ($urandom | 32'h1);
      for (int k = 0; k < 3; k++) q[k][i].push_back(v);
    end
  endtask

  task automatic clear(int i);
    for (int k = 0; k < 3; k++) q[k][i].delete();
  endtask

  task automatic drive();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) begin
        emp[k][i] = (q[k][i].size() == 0);
        dout[k][i*32 +: 32] = emp[k][i] ? $urandom : q[k][i][0];
      end
  endtask

  // One cycle: present inputs after the falling edge, check, advance the model, wait a cycle.
  task automatic step();
    logic [2:0]  r;
    logic [2:0]  erd;
    logic [31:0] word;
    int          w;
    int          frc;
    int          idx;
    bit          p;
    bit          ev;
    drive();
    #1;
    for (int k = 0; k < 3; k++) begin
      r = '0;
      for (int i = 0; i < 3; i++) r[i] = en[i] && (q[k][i].size() > 0);
      p   = !rst && !busy && (r != 3'b000);
      w   = -1;
      frc = -1;
      if (mode_of(k) == 0) begin
        for (int i = 0; i < 3; i++)
          if (frc < 0 && r[i] && wt[k][i] >= limit_of(k)) frc = i;
        for (int i = 0; i < 3; i++)
          if (w < 0 && r[i]) w = i;
        if (frc >= 0) w = frc;
      end else begin
        for (int o = 0; o < 3; o++) begin
          idx = (rrp[k] + o) % 3;
          if (w < 0 && r[idx]) w = idx;
        end
      end
      word = p ? q[k][w][0] : 32'h0;
      erd  = p ? (3'b001 << w) : 3'b000;
      ev   = p && (nf_of(k) == 0 || word != 0);
      chk("rd_en", k, 32'(rd[k]), 32'(erd));
      chk("valid", k, 32'(vld[k]), 32'(ev));
      chk("data", k, dat[k], word);
      chk("src", k, 32'(srcx[k]), p ? 32'(w) : 32'h0);
      chk("starve_force", k, 32'(sf[k]), 32'(p && frc >= 0));
      chk("nop_count", k, nop[k], 32'(nopm[k]));

      if (rst) begin
        rrp[k]  = 0;
        nopm[k] = 0;
        for (int i = 0; i < 3; i++) wt[k][i] = 0;
      end else begin
        if (mode_of(k) == 0)
          for (int i = 0; i < 3; i++) begin
            if (!r[i])          wt[k][i] = 0;
            else if (p && i == w) wt[k][i] = 0;
            else if (p && wt[k][i] < limit_of(k)) wt[k][i]++;
          end
        if (p) begin
          void'(q[k][w].pop_front());
          if (mode_of(k) == 1) rrp[k] = (w + 1) % 3;
          if (word == 0) nopm[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 3'b111;
    busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rrp[k] = 0;
      nopm[k] = 0;
      for (int i = 0; i < 3; i++) wt[k][i] = 0;
    end
    drive();
    @(negedge clk);

    // Reset holds off all pops even with full FIFOs.
    for (int i = 0; i < 3; i++) fill(i, 30, 0);
    step();
    step();
    rst = 1'b0;

    // All sources busy: strict-4 shows forced grants, strict-16 force after 16 losses, RR rotates.
    for (int c = 0; c < 22; c++) step();

    // Source 1 empty.
    clear(1);
    fill(0, 10, 0);
    fill(2, 10, 0);
    for (int c = 0; c < 8; c++) step();

    // NOP then a real order on source 0 only.
    for (int i = 0; i < 3; i++) clear(i);
    for (int k = 0; k < 3; k++) begin
      q[k][0].push_back(32'h0);
      q[k][0].push_back(32'h12345678);
    end
    for (int c = 0; c < 3; c++) step();

    // Engine busy for five cycles, then release.
    for (int i = 0; i < 3; i++) fill(i, 12, 0);
    busy = 1'b1;
    for (int c = 0; c < 5; c++) step();
    busy = 1'b0;
    for (int c = 0; c < 4; c++) step();

    // One-cycle reset in the middle of a stream.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) step();

    // Source 0 disabled while it still holds data.
    for (int i = 0; i < 3; i++) fill(i, 8, 0);
    en = 3'b110;
    for (int c = 0; c < 8; c++) step();
    en = 3'b111;

    // Randomised traffic with NOPs, busy, enables and occasional reset.
    for (int c = 0; c < 400; c++) begin
      en   = 3'($urandom_range(7));
      if ($urandom_range(3) != 0) en = 3'b111;
      busy = ($urandom_range(3) == 0);
      rst  = ($urandom_range(49) == 0);
      for (int i = 0; i < 3; i++)
        if (q[0][i].size() < 6 && $urandom_range(1) == 1) fill(i, $urandom_range(1, 3), 25);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
